key_debounce_capture: RTL and testbench

//  Parametrised debounce + edge-capture block for NUM_CH push-buttons (KEY bank, DE-series board).

---
 rtl/key_debounce_capture_if.sv | 26 ++
 rtl/key_debounce_capture.sv | 130 +++++++++++++
 tb/tb_key_debounce_capture.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_capture_if.sv
// Host-side register/status bundle for key_debounce_capture: debounced key state,
// edge pulses, sticky capture register and interrupt mask/line.
interface key_debounce_capture_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] key_level;
    logic [NUM_CH-1:0] key_press;
    logic [NUM_CH-1:0] key_release;
    logic [NUM_CH-1:0] capture;
    logic              capture_clr_wr;
    logic [NUM_CH-1:0] capture_clr_data;
    logic              irq_mask_wr;
    logic [NUM_CH-1:0] irq_mask_data;
    logic [NUM_CH-1:0] irq_mask;
    logic              irq;

    modport slave (
        input  capture_clr_wr, capture_clr_data, irq_mask_wr, irq_mask_data,
        output key_level, key_press, key_release, capture, irq_mask, irq
    );

    modport master (
        output capture_clr_wr, capture_clr_data, irq_mask_wr, irq_mask_data,
        input  key_level, key_press, key_release, capture, irq_mask, irq
    );
endinterface

// File: rtl/key_debounce_capture.sv
// Debounce + edge capture for a bank of push-buttons with a maskable level interrupt.
// Optional macro RELEASE_EDGE_EN: enables key_release pulses and capture on release.
module key_debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACTIVE_LOW      = 1,
    parameter bit REL_EN          = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int   CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic INACT = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             synced;

    assign synced = (ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1];

    // Any sample matching the accepted level wipes the count: no partial credit.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (synced == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = synced;
            cnt_d   = '0;
            rise_d  = synced;
            fall_d  = ~synced & REL_EN;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= {2{INACT}};
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pin_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

module key_debounce_capture #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [NUM_CH-1:0]    key_in,
    key_debounce_capture_if.slave bus
);
`ifdef RELEASE_EDGE_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic [NUM_CH-1:0] level, press, release_p;
    logic [NUM_CH-1:0] capture_q, capture_d;
    logic [NUM_CH-1:0] irq_mask_q, irq_mask_d;
    logic              irq_q, irq_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        key_debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW),
            .REL_EN         (REL_EN)
        ) u_lane (
            .clk_i  (clk_clk),
            .rst_ni (reset_reset_n),
            .pin_i  (key_in[g]),
            .level_o(level[g]),
            .rise_o (press[g]),
            .fall_o (release_p[g])
        );
    end

    // Set is OR-ed after the clear so a coincident event is never lost.
    always_comb begin
        capture_d  = capture_q;
        irq_mask_d = irq_mask_q;
        if (bus.capture_clr_wr) capture_d = capture_d & ~bus.capture_clr_data;
        capture_d = capture_d | press | release_p;
        if (bus.irq_mask_wr) irq_mask_d = bus.irq_mask_data;
        irq_d = |(capture_q & irq_mask_q);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            capture_q  <= '0;
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            capture_q  <= capture_d;
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.key_level   = level;
    assign bus.key_press   = press;
    assign bus.key_release = release_p;
    assign bus.capture     = capture_q;
    assign bus.irq_mask    = irq_mask_q;
    assign bus.irq         = irq_q;
endmodule

// File: tb/tb_key_debounce_capture.sv
// Directed bench for key_debounce_capture with DEBOUNCE_CYCLES=4, NUM_CH=4, active-low keys.
module tb_key_debounce_capture;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_in;
    int         checks = 0;
    int         failures = 0;

    key_debounce_capture_if #(.NUM_CH(4)) bus ();

    key_debounce_capture #(
        .NUM_CH(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .key_in       (key_in),
        .bus          (bus)
    );

    always #5 clk = ~clk;

`ifdef RELEASE_EDGE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        key_in = 4'hF;
        rst_n  = 1'b0;
        bus.capture_clr_wr = 1'b0; bus.capture_clr_data = '0;
        bus.irq_mask_wr = 1'b0;    bus.irq_mask_data = '0;
        tick(3);
        checks++; if ({bus.key_level, bus.key_press, bus.key_release, bus.capture} !== 16'h0) begin
            failures++; $display("FAIL reset_outs got=%h want=0", {bus.key_level, bus.key_press, bus.key_release, bus.capture});
        end
        checks++; if ({bus.irq_mask, bus.irq} !== 5'h0) begin
            failures++; $display("FAIL reset_irq got=%h want=0", {bus.irq_mask, bus.irq});
        end
        rst_n = 1'b1;
        begin
            int bad = 0;
            for (int i = 0; i < 20; i++) begin
                tick(1);
                if (bus.key_level !== 4'h0 || bus.key_press !== 4'h0) bad++;
            end
            checks++; if (bad != 0) begin
                failures++; $display("FAIL idle_level bad_cycles=%0d want=0", bad);
            end
        end
    endtask

    task automatic test_press;
        key_in = 4'b1110;
        tick(5);
        checks++; if (bus.key_level !== 4'h0) begin
            failures++; $display("FAIL press_early got=%h want=0", bus.key_level);
        end
        tick(1);
        checks++; if (bus.key_level !== 4'h1 || bus.key_press !== 4'h1) begin
            failures++; $display("FAIL press_edge level=%h press=%h want=1/1", bus.key_level, bus.key_press);
        end
        tick(1);
        checks++; if (bus.key_press !== 4'h0 || bus.capture !== 4'h1) begin
            failures++; $display("FAIL press_after press=%h capture=%h want=0/1", bus.key_press, bus.capture);
        end
    endtask

    task automatic test_bounce;
        int bad = 0;
        for (int i = 0; i < 10; i++) begin
            key_in[1] = ~key_in[1];
            for (int j = 0; j < 2; j++) begin
                tick(1);
                if (bus.key_level !== 4'h1 || bus.key_press !== 4'h0) bad++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.key_level !== 4'h1 || bus.key_press !== 4'h0) bad++;
        end
        checks++; if (bad != 0) begin
            failures++; $display("FAIL bounce_filter bad_cycles=%0d want=0", bad);
        end
    endtask

    task automatic test_clr_vs_set;
        key_in = 4'b1100;
        tick(7);
        checks++; if (bus.capture !== 4'h3) begin
            failures++; $display("FAIL capture_two got=%h want=3", bus.capture);
        end
        key_in = 4'b1101;
        tick(8);
        key_in = 4'b1100;
        tick(6);
        checks++; if (bus.key_press !== 4'h1) begin
            failures++; $display("FAIL repress_pulse got=%h want=1", bus.key_press);
        end
        bus.capture_clr_wr = 1'b1; bus.capture_clr_data = 4'h1;
        tick(1);
        checks++; if (bus.capture !== 4'h3) begin
            failures++; $display("FAIL set_wins got=%h want=3", bus.capture);
        end
        bus.capture_clr_data = 4'h2;
        tick(1);
        checks++; if (bus.capture !== 4'h1) begin
            failures++; $display("FAIL clear_bit1 got=%h want=1", bus.capture);
        end
        bus.capture_clr_data = 4'h8;
        tick(1);
        bus.capture_clr_wr = 1'b0;
        checks++; if (bus.capture !== 4'h1) begin
            failures++; $display("FAIL clear_zero_bit got=%h want=1", bus.capture);
        end
    endtask

    task automatic test_irq;
        key_in = 4'b1000;
        tick(7);
        checks++; if (bus.capture !== 4'h5 || bus.irq !== 1'b0) begin
            failures++; $display("FAIL masked_irq capture=%h irq=%b want=5/0", bus.capture, bus.irq);
        end
        bus.irq_mask_wr = 1'b1; bus.irq_mask_data = 4'h4;
        tick(1);
        bus.irq_mask_wr = 1'b0;
        checks++; if (bus.irq_mask !== 4'h4 || bus.irq !== 1'b0) begin
            failures++; $display("FAIL mask_load mask=%h irq=%b want=4/0", bus.irq_mask, bus.irq);
        end
        tick(1);
        checks++; if (bus.irq !== 1'b1) begin
            failures++; $display("FAIL irq_rise got=%b want=1", bus.irq);
        end
        bus.capture_clr_wr = 1'b1; bus.capture_clr_data = 4'h4;
        tick(1);
        bus.capture_clr_wr = 1'b0;
        checks++; if (bus.capture !== 4'h1 || bus.irq !== 1'b1) begin
            failures++; $display("FAIL irq_clr_lag capture=%h irq=%b want=1/1", bus.capture, bus.irq);
        end
        tick(1);
        checks++; if (bus.irq !== 1'b0) begin
            failures++; $display("FAIL irq_fall got=%b want=0", bus.irq);
        end
    endtask

    task automatic test_release;
        bus.capture_clr_wr = 1'b1; bus.capture_clr_data = 4'hF;
        tick(1);
        bus.capture_clr_wr = 1'b0;
        key_in = 4'b1001;
        tick(6);
        checks++; if (bus.key_level !== 4'h6 || bus.key_release !== {3'b000, REL} || bus.key_press !== 4'h0) begin
            failures++; $display("FAIL release_edge level=%h rel=%h press=%h want=6/%0d/0", bus.key_level, bus.key_release, bus.key_press, REL);
        end
        tick(1);
        checks++; if (bus.capture !== {3'b000, REL} || bus.key_release !== 4'h0) begin
            failures++; $display("FAIL release_capture capture=%h rel=%h want=%0d/0", bus.capture, bus.key_release, REL);
        end
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        key_in = 4'b0001;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        checks++; if (bus.key_level !== 4'h0 || bus.capture !== 4'h0 || bus.irq_mask !== 4'h0) begin
            failures++; $display("FAIL mid_reset level=%h capture=%h mask=%h want=0/0/0", bus.key_level, bus.capture, bus.irq_mask);
        end
        key_in = 4'hF;
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.key_level !== 4'h0 || bus.key_press !== 4'h0 || bus.key_release !== 4'h0) bad++;
        end
        checks++; if (bad != 0) begin
            failures++; $display("FAIL post_reset_quiet bad_cycles=%0d want=0", bad);
        end
    endtask

    task automatic test_simultaneous;
        key_in = 4'b1001;
        tick(6);
        checks++; if (bus.key_press !== 4'h6 || bus.key_level !== 4'h6) begin
            failures++; $display("FAIL simul_press press=%h level=%h want=6/6", bus.key_press, bus.key_level);
        end
        tick(1);
        checks++; if (bus.capture !== 4'h6) begin
            failures++; $display("FAIL simul_capture got=%h want=6", bus.capture);
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_clr_vs_set();
        test_irq();
        test_release();
        test_reset_mid();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
